nib_link_rx: RTL and testbench
==============================

Name: nib_link_rx

Overview:
- Receive end of the inverted-nibble link. The transmit side drives each nibble bit-inverted on a 4-bit bus, with a strobe and a first-nibble marker.
- This block synchronises the link pins and un-inverts each nibble. It pairs nibbles into bytes (high nibble first) and buffers them in a small FIFO.
- Bytes leave on a valid/ready interface. It sits between the ui_in pins and the consuming logic of a Tiny Tapeout tile.

Parameters:
- FIFO_DEPTH, 4, byte entries; power of two, minimum 2.
- SYNC_STAGES, 2, flop stages on every link input; minimum 2.
- TIMEOUT_CYCLES, 255, max cycles in HAVE_HI before the held nibble is dropped; used only with NIB_LINK_RX_TIMEOUT_EN.

Ports:
- clk, input, 1, sole clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- nib_in, input, 4, link data, bit-inverted on the wire; asynchronous.
- nib_stb, input, 1, link strobe; each rising edge carries one nibble; asynchronous.
- nib_first, input, 1, high = this nibble is the high nibble of a byte; asynchronous.
- out_data, output, 8, FIFO head byte.
- out_valid, output, 1, FIFO not empty.
- out_ready, input, 1, consumer accepts head when out_valid && out_ready.
- sync_err, output, 1, one-cycle pulse on framing error or timeout.
- overflow, output, 1, sticky: a byte was dropped because the FIFO was full.
- ovf_clr, input, 1, clears overflow.

Behaviour:
- Reset (synchronous, active-high): all outputs 0; FIFO empty; state IDLE; sync chains 0; strobe edge history 0.
  - A strobe that is already high when rst deasserts is not seen as an edge.
- Sync: nib_in, nib_stb and nib_first each pass through SYNC_STAGES flops. Edge = synced stb high while previous synced stb low.
  - Transmitter holds nib_in and nib_first stable from 1 cycle before to SYNC_STAGES+1 cycles after the stb rise.
- Nibble value = ~synced nib_in.
- FSM, on an edge:
  - IDLE, first=1: hi <= nibble; go to HAVE_HI.
  - IDLE, first=0: pulse sync_err; nibble discarded; stay IDLE.
  - HAVE_HI, first=0: push {hi, nibble}; go to IDLE.
  - HAVE_HI, first=1: pulse sync_err; hi <= nibble (resync); stay HAVE_HI.
- FIFO:
  - Push accepted if not full, or if a pop happens in the same cycle. Otherwise the byte is dropped and overflow is set.
  - Set of overflow has priority over ovf_clr in the same cycle.
  - Pop when out_valid && out_ready.
  - out_data is registered from the head and stable while out_valid && !out_ready.
  - Pointers wrap modulo FIFO_DEPTH; one extra bit distinguishes full from empty.
- Latency: out_valid rises exactly SYNC_STAGES+2 edges after the first edge that samples the low-nibble nib_stb high, when the FIFO was empty.
- Throughput: at most one nibble per SYNC_STAGES+1 cycles (stb high ≥ SYNC_STAGES+1, low ≥ SYNC_STAGES+1).
- Reset mid-byte: the held hi nibble is discarded and no byte is pushed.

Optional Feature:
- Macro: NIB_LINK_RX_TIMEOUT_EN.
- With the macro: an 8..16-bit counter runs while in HAVE_HI and clears on every edge.
  - When it reaches TIMEOUT_CYCLES: go to IDLE, pulse sync_err, drop hi.
  - An edge in the same cycle as the timeout wins: the normal transition applies.
- Without the macro: no counter; HAVE_HI waits indefinitely.

Decomposition:
- Package nib_link_pkg holds:
  - NIB_W=4 and BYTE_W=8.
  - enum rx_state_t {IDLE, HAVE_HI}.
  - WIRE_INV_MASK=4'hF.
- One sub-module, nib_link_fifo: synchronous FIFO with push/pop/full/empty, parameterised by FIFO_DEPTH.

Test Plan:
- Send hi wire 0x5 (first=1), then lo wire 0xA (first=0) -> out_data=0xA5, out_valid high SYNC_STAGES+2 cycles after the lo strobe; sync_err never pulses.
- out_ready=0, send 5 bytes 0x00..0x04 with FIFO_DEPTH=4 -> bytes 0x00..0x03 held, overflow=1; raise out_ready -> 0x00..0x03 drain in order; ovf_clr -> overflow=0.
- Send lo nibble (first=0) while IDLE -> sync_err pulses 1 cycle, nothing pushed; then a valid pair wire 0xE,0x1 -> 0x1E.
- Send hi wire 0x0, hi wire 0xF, lo wire 0x3 -> one sync_err, single byte 0x0C.
- Send hi nibble, assert rst for 1 cycle, then lo nibble -> sync_err pulses, no byte, out_valid stays 0.
- With NIB_LINK_RX_TIMEOUT_EN, TIMEOUT_CYCLES=20: send hi nibble, idle 30 cycles, send lo -> sync_err at timeout, then a second sync_err on lo, no byte.

Source files
------------

// File: rtl/nib_link_pkg.sv
// Shared widths, wire polarity and receiver state type for the inverted-nibble link.
package nib_link_pkg;

   localparam int unsigned NIB_W  = 4;
   localparam int unsigned BYTE_W = 8;

   localparam logic [NIB_W-1:0] WIRE_INV_MASK = 4'hF;

   typedef enum logic {
      IDLE,
      HAVE_HI
   } rx_state_t;

endpackage

// File: rtl/nib_link_rx_if.sv
// Byte stream leaving the link receiver: valid/ready with registered data.
interface nib_link_rx_if;
   import nib_link_pkg::*;

   logic [BYTE_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/nib_link_fifo.sv
// Synchronous byte FIFO; head and valid are registered from next-state pointers.
module nib_link_fifo
   import nib_link_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [BYTE_W-1:0] push_data,
   input  logic              pop,
   output logic              full_c,
   output logic [BYTE_W-1:0] head,
   output logic              valid
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [BYTE_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]     wptr;
   logic [PW-1:0]     rptr;
   logic [PW-1:0]     wptr_n;
   logic [PW-1:0]     rptr_n;
   logic              do_push;

   assign full_c  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_push = push && (!full_c || pop);
   assign wptr_n  = wptr + PW'(do_push);
   assign rptr_n  = rptr + PW'(pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr[AW-1:0]] <= push_data;
   end

   // New head is the slot being written this cycle when it lands on an empty queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         valid <= 1'b0;
         head  <= '0;
      end else begin
         wptr  <= wptr_n;
         rptr  <= rptr_n;
         valid <= (wptr_n != rptr_n);
         if (wptr_n != rptr_n) head <= (rptr_n == wptr) ? push_data : mem[rptr_n[AW-1:0]];
      end
   end

endmodule

// File: rtl/nib_link_rx.sv
// Inverted-nibble link receiver: sync, un-invert, pair nibbles into bytes, buffer.
// Optional hi-nibble timeout enabled by defining NIB_LINK_RX_TIMEOUT_EN.
module nib_link_rx
   import nib_link_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned SYNC_STAGES = 2
`ifdef NIB_LINK_RX_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NIB_W-1:0] nib_in,
   input  logic             nib_stb,
   input  logic             nib_first,
   nib_link_rx_if.master    rx_out,
   output logic             sync_err,
   output logic             overflow,
   input  logic             ovf_clr
);

   logic [NIB_W-1:0]       nib_sync [SYNC_STAGES];
   logic [SYNC_STAGES-1:0] stb_sync;
   logic [SYNC_STAGES-1:0] first_sync;
   logic [SYNC_STAGES-1:0] settle;
   logic                   stb_s;
   logic                   armed;
   logic                   stb_prev;
   logic                   edge_q;
   logic                   first_q;
   logic [NIB_W-1:0]       nib_q;

   rx_state_t         state;
   logic [NIB_W-1:0]  hi;
   logic              push_q;
   logic [BYTE_W-1:0] push_data;
   logic              pop;
   logic              full_c;

   assign stb_s = stb_sync[SYNC_STAGES-1];
   assign pop   = rx_out.out_valid && rx_out.out_ready;

   // Edges are only armed once the chain has filled and shown a low strobe,
   // so a strobe held high across reset is never taken as a nibble.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) nib_sync[i] <= '0;
         stb_sync   <= '0;
         first_sync <= '0;
         settle     <= '0;
         armed      <= 1'b0;
         stb_prev   <= 1'b0;
         edge_q     <= 1'b0;
         first_q    <= 1'b0;
         nib_q      <= '0;
      end else begin
         nib_sync[0] <= nib_in;
         for (int i = 1; i < int'(SYNC_STAGES); i++) nib_sync[i] <= nib_sync[i-1];
         stb_sync   <= {stb_sync[SYNC_STAGES-2:0], nib_stb};
         first_sync <= {first_sync[SYNC_STAGES-2:0], nib_first};
         settle     <= {settle[SYNC_STAGES-2:0], 1'b1};
         if (settle[SYNC_STAGES-1] && !stb_s) armed <= 1'b1;
         stb_prev   <= stb_s;
         edge_q     <= armed && stb_s && !stb_prev;
         nib_q      <= nib_sync[SYNC_STAGES-1] ^ WIRE_INV_MASK;
         first_q    <= first_sync[SYNC_STAGES-1];
      end
   end

`ifdef NIB_LINK_RX_TIMEOUT_EN
   localparam int unsigned TMO_W = 16;
   logic [TMO_W-1:0] tmo_cnt;
`endif

   // Pairing FSM: a first-marked nibble always (re)loads hi; a plain nibble completes a byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hi        <= '0;
         push_q    <= 1'b0;
         push_data <= '0;
         sync_err  <= 1'b0;
`ifdef NIB_LINK_RX_TIMEOUT_EN
         tmo_cnt   <= '0;
`endif
      end else begin
         push_q   <= 1'b0;
         sync_err <= 1'b0;
`ifdef NIB_LINK_RX_TIMEOUT_EN
         tmo_cnt  <= '0;
`endif
         case (state)
            IDLE: begin
               if (edge_q) begin
                  if (first_q) begin
                     hi    <= nib_q;
                     state <= HAVE_HI;
                  end else begin
                     sync_err <= 1'b1;
                  end
               end
            end
            HAVE_HI: begin
               if (edge_q) begin
                  if (first_q) begin
                     sync_err <= 1'b1;
                     hi       <= nib_q;
                  end else begin
                     push_q    <= 1'b1;
                     push_data <= {hi, nib_q};
                     state     <= IDLE;
                  end
               end
`ifdef NIB_LINK_RX_TIMEOUT_EN
               else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES)) begin
                  sync_err <= 1'b1;
                  state    <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TMO_W'(1);
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   nib_link_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_q),
      .push_data (push_data),
      .pop       (pop),
      .full_c    (full_c),
      .head      (rx_out.out_data),
      .valid     (rx_out.out_valid)
   );

   // A dropped byte sets the flag even when a clear arrives in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (push_q && full_c && !pop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nib_link_rx.sv
// Self-checking bench for nib_link_rx: vector table, directed corner cases, random nibble stream.
module tb_nib_link_rx;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int unsigned FIFO_DEPTH  = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] nib_in;
   logic       nib_stb;
   logic       nib_first;
   logic       sync_err;
   logic       overflow;
   logic       ovf_clr;

   nib_link_rx_if rx_out ();

   nib_link_rx #(
      .FIFO_DEPTH  (FIFO_DEPTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .nib_in    (nib_in),
      .nib_stb   (nib_stb),
      .nib_first (nib_first),
      .rx_out    (rx_out),
      .sync_err  (sync_err),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   bit   rnd_ready = 1'b0;

   logic [7:0] got_q [$];
   int         err_cyc = 0;
   int         err_pulse = 0;
   logic       err_prev = 1'b0;
   bit         seen_valid = 1'b0;

   // Observer: handshakes and sync_err activity, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_out.out_valid && rx_out.out_ready) got_q.push_back(rx_out.out_data);
         if (rx_out.out_valid) seen_valid <= 1'b1;
         if (sync_err) err_cyc <= err_cyc + 1;
         if (sync_err && !err_prev) err_pulse <= err_pulse + 1;
         err_prev <= sync_err;
      end else begin
         err_prev <= 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_ready) rx_out.out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send_nib(input logic [3:0] w, input logic f);
      nib_in    = w;
      nib_first = f;
      tick();
      nib_stb = 1'b1;
      repeat (SYNC_STAGES + 2) tick();
      nib_stb = 1'b0;
      repeat (SYNC_STAGES + 2) tick();
   endtask

   task automatic send_pair(input logic [3:0] hw, input logic [3:0] lw);
      send_nib(hw, 1'b1);
      send_nib(lw, 1'b0);
   endtask

   task automatic expect_bytes(input string name, input logic [7:0] exp_q [$]);
      check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (got_q.size() > 0) check(name, 32'(got_q.pop_front()), 32'(exp_q[i]));
         else check({name, "_missing"}, 32'hFFFF_FFFF, 32'(exp_q[i]));
      end
      got_q.delete();
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0] hi_w;
      logic [3:0] lo_w;
      logic [7:0] exp;
   } vec_t;

   initial begin
      vec_t       vecs [7];
      logic [7:0] eq [$];
      int         e0;
      int         c0;
      int         lat;
      logic [7:0] nb;
      logic [3:0] rw [$];
      logic       rf [$];
      int         held;
      int         exp_err;
      logic [3:0] nv;

      vecs[0] = '{4'h5, 4'hA, 8'hA5};
      vecs[1] = '{4'hE, 4'h1, 8'h1E};
      vecs[2] = '{4'h0, 4'h0, 8'hFF};
      vecs[3] = '{4'hF, 4'hF, 8'h00};
      vecs[4] = '{4'h3, 4'hC, 8'hC3};
      vecs[5] = '{4'h7, 4'h8, 8'h87};
      vecs[6] = '{4'h9, 4'h6, 8'h69};

      rst = 1'b1; nib_in = 4'h0; nib_stb = 1'b0; nib_first = 1'b0;
      ovf_clr = 1'b0; rx_out.out_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_out_valid", 32'(rx_out.out_valid), 32'd0);
      check("rst_out_data", 32'(rx_out.out_data), 32'd0);
      check("rst_sync_err", 32'(sync_err), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      repeat (6) tick();

      // First-byte latency and value
      rx_out.out_ready = 1'b1;
      e0 = err_cyc;
      send_nib(4'h5, 1'b1);
      nib_in = 4'hA; nib_first = 1'b0;
      tick();
      nib_stb = 1'b1;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (rx_out.out_valid) begin
            lat = k;
            check("latency_data", 32'(rx_out.out_data), 32'hA5);
            break;
         end
      end
      check("latency_edges", 32'(lat), 32'(SYNC_STAGES + 3));
      nib_stb = 1'b0;
      repeat (SYNC_STAGES + 4) tick();
      check("latency_no_err", 32'(err_cyc - e0), 32'd0);
      got_q.delete();

      // Table of byte pairs
      for (int i = 0; i < 7; i++) begin
         e0 = err_cyc;
         send_pair(vecs[i].hi_w, vecs[i].lo_w);
         repeat (3) tick();
         eq = '{vecs[i].exp};
         expect_bytes($sformatf("vec%0d", i), eq);
         check($sformatf("vec%0d_err", i), 32'(err_cyc - e0), 32'd0);
      end

      // Overflow with consumer stalled
      rx_out.out_ready = 1'b0;
      for (int b = 0; b < 5; b++) begin
         nb = ~8'(b);
         send_pair(nb[7:4], nb[3:0]);
         repeat (2) tick();
         if (b == 3) check("ovf_at_depth", 32'(overflow), 32'd0);
      end
      check("ovf_set", 32'(overflow), 32'd1);
      check("ovf_head_valid", 32'(rx_out.out_valid), 32'd1);
      check("ovf_head_data", 32'(rx_out.out_data), 32'h00);
      rx_out.out_ready = 1'b1;
      repeat (8) tick();
      eq = '{8'h00, 8'h01, 8'h02, 8'h03};
      expect_bytes("drain", eq);
      check("ovf_sticky", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      tick();
      check("ovf_clr", 32'(overflow), 32'd0);

      // Low nibble while idle, then a good pair
      e0 = err_cyc; c0 = err_pulse;
      send_nib(4'h3, 1'b0);
      repeat (3) tick();
      check("lone_lo_err", 32'(err_cyc - e0), 32'd1);
      check("lone_lo_pulse", 32'(err_pulse - c0), 32'd1);
      check("lone_lo_nobyte", 32'(got_q.size()), 32'd0);
      send_pair(4'hE, 4'h1);
      repeat (3) tick();
      eq = '{8'h1E};
      expect_bytes("after_lone_lo", eq);

      // Double high nibble resyncs
      e0 = err_cyc;
      send_nib(4'h0, 1'b1);
      send_nib(4'hF, 1'b1);
      send_nib(4'h3, 1'b0);
      repeat (3) tick();
      check("resync_err", 32'(err_cyc - e0), 32'd1);
      eq = '{8'h0C};
      expect_bytes("resync", eq);

      // Reset mid-byte
      e0 = err_cyc;
      send_nib(4'h2, 1'b1);
      seen_valid = 1'b0;
      pulse_rst();
      repeat (6) tick();
      send_nib(4'h4, 1'b0);
      repeat (3) tick();
      check("midrst_err", 32'(err_cyc - e0), 32'd1);
      check("midrst_valid", 32'(seen_valid), 32'd0);
      check("midrst_nobyte", 32'(got_q.size()), 32'd0);

      // Strobe held high across reset is not a nibble
      e0 = err_cyc;
      nib_in = 4'h0; nib_first = 1'b0;
      rst = 1'b1;
      tick();
      nib_stb = 1'b1;
      tick();
      rst = 1'b0;
      repeat (8) tick();
      nib_stb = 1'b0;
      repeat (4) tick();
      check("stb_high_rst_err", 32'(err_cyc - e0), 32'd0);
      send_pair(4'h9, 4'h6);
      repeat (3) tick();
      eq = '{8'h69};
      expect_bytes("after_stb_high_rst", eq);

      // Random nibble stream against a pairing model
      for (int i = 0; i < 60; i++) begin
         rw.push_back(4'($urandom_range(0, 15)));
         rf.push_back(($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1);
      end
      held = -1; exp_err = 0; eq = {};
      foreach (rw[i]) begin
         nv = ~rw[i];
         if (rf[i]) begin
            if (held >= 0) exp_err++;
            held = int'(nv);
         end else if (held < 0) begin
            exp_err++;
         end else begin
            eq.push_back(8'(held * 16 + int'(nv)));
            held = -1;
         end
      end
      e0 = err_cyc; c0 = err_pulse;
      rnd_ready = 1'b1;
      foreach (rw[i]) send_nib(rw[i], rf[i]);
      rnd_ready = 1'b0;
      rx_out.out_ready = 1'b1;
      repeat (20) tick();
      check("rand_err_cycles", 32'(err_cyc - e0), 32'(exp_err));
      check("rand_err_pulses", 32'(err_pulse - c0), 32'(exp_err));
      check("rand_no_ovf", 32'(overflow), 32'd0);
      expect_bytes("rand", eq);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #300000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
